bird_y_filter: RTL

BIRD_Y_FILTER -- requirements
Module: bird_y_filter

---
 rtl/bird_y_filter_if.sv | 11 +
 rtl/bird_y_filter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bird_y_filter_if.sv
// Camera-side frame signals and filtered bird position outputs of the bird_y filter.
interface bird_y_filter_if;
    logic               vsync;
    logic signed [31:0] y_in;
    logic [9:0]         bird_y;
    logic               y_valid;
    logic               frame_tick;

    modport master (output vsync, output y_in, input bird_y, input y_valid, input frame_tick);
    modport slave  (input vsync, input y_in, output bird_y, output y_valid, output frame_tick);
endinterface

// File: rtl/bird_y_filter.sv
// Per-frame bird row filter: vsync edge detect, moving average over DEPTH frames,
// rate-limited tracking with a miss timeout that drops lock back to acquisition.
module bird_y_filter #(
    parameter int DEPTH    = 4,
    parameter int MAX_STEP = 8,
    parameter int TIMEOUT  = 30,
    parameter int Y_MAX    = 239
) (
    input logic            clk,
    input logic            reset_n,
    bird_y_filter_if.slave bus
);
    localparam int LOG2D = $clog2(DEPTH);
    localparam int SW    = 8 + LOG2D;
    localparam int MW    = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    localparam logic [9:0]         BIRD_RST = 10'(2 * ((Y_MAX + 1) / 2));
    localparam logic signed [10:0] STEP_S   = 11'(MAX_STEP);
    localparam logic [9:0]         STEP_U   = 10'(MAX_STEP);
    localparam logic [MW-1:0]      MISS_LIM = MW'(TIMEOUT);
    localparam logic signed [31:0] Y_MAX_S  = 32'(Y_MAX);

    logic          vs_meta_r, vs_sync_r, vs_prev_r, armed_r;
    logic [1:0]    settle_r;
    logic          frame_ev_s, in_range_s;
    logic          pend_r, samp_ok_r;
    logic [7:0]    samp_r;
    logic [7:0]    hist_r [DEPTH];
    logic [SW-1:0] sum_r, sum_n, sum_shift_s;
    logic [1:0]    state_r, state_n;
    logic [MW-1:0] miss_r, miss_n, miss_inc_s;
    logic [9:0]    bird_y_r, bird_n, target_s, moved_s;
    logic          y_valid_r, valid_n, frame_tick_r;
    logic          fill_s, shift_s;
    logic signed [10:0] diff_s;

    // Synchronize vsync; edges only count once a low level has been seen after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_meta_r <= 1'b0;
            vs_sync_r <= 1'b0;
            vs_prev_r <= 1'b0;
            settle_r  <= 2'b00;
            armed_r   <= 1'b0;
        end else begin
            vs_meta_r <= bus.vsync;
            vs_sync_r <= vs_meta_r;
            vs_prev_r <= vs_sync_r;
            settle_r  <= {settle_r[0], 1'b1};
            armed_r   <= armed_r | (settle_r[1] & ~vs_sync_r);
        end
    end

    assign frame_ev_s = armed_r & vs_sync_r & ~vs_prev_r;
    assign in_range_s = (bus.y_in >= 32'sd0) && (bus.y_in <= Y_MAX_S);

    // Capture the frame sample and its validity in the cycle after the event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_r    <= 1'b0;
            samp_r    <= 8'd0;
            samp_ok_r <= 1'b0;
        end else begin
            pend_r <= frame_ev_s;
            if (frame_ev_s) begin
                samp_r    <= bus.y_in[7:0];
                samp_ok_r <= in_range_s;
            end
        end
    end

    // Moving-average target and the rate-limited step toward it
    always_comb begin
        sum_shift_s = sum_r + SW'(samp_r) - SW'(hist_r[DEPTH-1]);
        target_s    = {1'b0, sum_shift_s[SW-1:LOG2D], 1'b0};
        diff_s      = $signed({1'b0, target_s}) - $signed({1'b0, bird_y_r});
        if (diff_s > STEP_S) begin
            moved_s = bird_y_r + STEP_U;
        end else if (diff_s < -STEP_S) begin
            moved_s = bird_y_r - STEP_U;
        end else begin
            moved_s = target_s;
        end
    end

    assign miss_inc_s = miss_r + MW'(1);

    // Lock state machine, applied once per processed frame sample
    always_comb begin
        state_n = state_r;
        miss_n  = miss_r;
        sum_n   = sum_r;
        bird_n  = bird_y_r;
        valid_n = y_valid_r;
        fill_s  = 1'b0;
        shift_s = 1'b0;
        if (pend_r) begin
            case (state_r)
                ST_ACQUIRE: begin
                    if (samp_ok_r) begin
                        fill_s  = 1'b1;
                        sum_n   = SW'(samp_r) << LOG2D;
                        bird_n  = {1'b0, samp_r, 1'b0};
                        valid_n = 1'b1;
                        miss_n  = '0;
                        state_n = ST_TRACK;
                    end else begin
                        state_n = ST_ACQUIRE;
                    end
                end
                ST_TRACK, ST_HOLD: begin
                    if (samp_ok_r) begin
                        shift_s = 1'b1;
                        sum_n   = sum_shift_s;
                        bird_n  = moved_s;
                        miss_n  = '0;
                        state_n = ST_TRACK;
                    end else if (state_r == ST_TRACK) begin
                        miss_n  = MW'(1);
                        state_n = ST_HOLD;
                    end else if (miss_inc_s == MISS_LIM) begin
                        miss_n  = miss_inc_s;
                        valid_n = 1'b0;
                        state_n = ST_ACQUIRE;
                    end else begin
                        miss_n  = miss_inc_s;
                    end
                end
                default: begin
                    valid_n = 1'b0;
                    state_n = ST_ACQUIRE;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // History buffer: fill on acquisition, shift on each tracked sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) hist_r[i] <= 8'd0;
        end else if (fill_s) begin
            for (int i = 0; i < DEPTH; i++) hist_r[i] <= samp_r;
        end else if (shift_s) begin
            hist_r[0] <= samp_r;
            for (int i = 1; i < DEPTH; i++) hist_r[i] <= hist_r[i-1];
        end
    end

    // State, running sum and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_ACQUIRE;
            miss_r       <= '0;
            sum_r        <= '0;
            bird_y_r     <= BIRD_RST;
            y_valid_r    <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            miss_r       <= miss_n;
            sum_r        <= sum_n;
            bird_y_r     <= bird_n;
            y_valid_r    <= valid_n;
            frame_tick_r <= pend_r;
        end
    end

    assign bus.bird_y     = bird_y_r;
    assign bus.y_valid    = y_valid_r;
    assign bus.frame_tick = frame_tick_r;
endmodule
